// File: rtl/mmio_uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package mmio_uart_pkg;

    // Serializer frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Byte offsets of the two registers inside the window.
    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    // STATUS register bit positions.
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_FULL_BIT = 1;
    localparam int STATUS_OVF_BIT  = 2;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead output; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; occupancy is tracked by the pointers, so stale entries are never read.
        if (push_ok) mem[wr_ptr_q] <= din;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus UART transmitter: TXDATA stores queue bytes, which are sent 8N1
// LSB first on tx; STATUS reports busy/full/overflow and a store clears overflow.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 174,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int                CW        = $clog2(FIFO_DEPTH);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              overflow_q, overflow_d;

    logic              txdata_wr;
    logic              status_wr;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CW:0]       fifo_count;
    logic              unused_wdata;

    assign txdata_wr    = MemWrite && (DataAddr == BASE_ADDR + TXDATA_OFS);
    assign status_wr    = MemWrite && (DataAddr == BASE_ADDR + STATUS_OFS);
    assign fifo_pop     = (state_q == IDLE) && !fifo_empty;
    assign unused_wdata = ^WriteData[31:8];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (txdata_wr),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);
    assign overflow = overflow_q;

    // Sticky overflow: set by a dropped TXDATA store, cleared by any STATUS store.
    always_comb begin
        overflow_d = overflow_q;
        if (txdata_wr && fifo_full && !fifo_pop) overflow_d = 1'b1;
        else if (status_wr)                     overflow_d = 1'b0;
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    // Combinational read port; only STATUS returns non-zero data.
    always_comb begin
        ReadData = '0;
        if (DataAddr == BASE_ADDR + STATUS_OFS) begin
            ReadData[STATUS_OVF_BIT]  = overflow_q;
            ReadData[STATUS_FULL_BIT] = fifo_full;
            ReadData[STATUS_BUSY_BIT] = busy;
        end
    end

    // Frame serializer with baud counter and registered tx output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_dout;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE=0x100.
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       stop_ok;
    } frame_t;

    frame_t frames[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_busy;
        logic        exp_ovf;
    } vec_t;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAddr  (DataAddr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the store is captured by the next rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAddr  = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Line monitor: decodes frames by sampling each bit one cycle into its cell.
    initial begin
        int         k;
        int         st;
        logic [7:0] b;
        k  = -1;
        st = 0;
        b  = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                k = -1;
            end else if (k < 0) begin
                if (tx === 1'b0) begin
                    k  = 0;
                    st = cycle;
                end
            end else begin
                k++;
                if (k >= 5 && k <= 33 && (k % 4) == 1) b[(k - 5) / 4] = tx;
                if (k == 37) frames.push_back('{data: b, start: st, stop_ok: (tx === 1'b1)});
                if (k == 39) k = -1;
            end
        end
    end

    initial begin
        vec_t       vecs[7];
        logic [9:0] fr;

        vecs[0] = '{we: 1'b0, addr: BASE + 32'h4, wdata: 32'h0,   exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};
        vecs[1] = '{we: 1'b0, addr: BASE,         wdata: 32'h0,   exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};
        vecs[2] = '{we: 1'b1, addr: 32'h0000_000C, wdata: 32'h248, exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};
        vecs[3] = '{we: 1'b1, addr: BASE + 32'h8, wdata: 32'hFF,  exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};
        vecs[4] = '{we: 1'b0, addr: 32'h0000_000C, wdata: 32'h0,   exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};
        vecs[5] = '{we: 1'b1, addr: BASE + 32'h4, wdata: 32'h0,   exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};
        vecs[6] = '{we: 1'b0, addr: BASE + 32'h4, wdata: 32'h0,   exp_rdata: 32'h0, exp_busy: 1'b0, exp_ovf: 1'b0};

        MemWrite  = 1'b0;
        DataAddr  = 32'h0;
        WriteData = 32'h0;
        reset     = 1'b0;
        #22;
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_ovf", {31'b0, overflow}, 32'd0);
        DataAddr = BASE + 32'h4;
        #1;
        check("reset_status", ReadData, 32'h0);

        // Register map and decode isolation table
        for (int i = 0; i < 7; i++) begin
            MemWrite  = vecs[i].we;
            DataAddr  = vecs[i].addr;
            WriteData = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rdata);
            @(negedge clk);
            MemWrite = 1'b0;
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
            check($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
        end
        repeat (30) @(negedge clk);
        check("decode_no_frame", 32'(frames.size()), 32'd0);
        check("decode_tx_idle", {31'b0, tx}, 32'd1);

        // Single byte 0x55, cycle-by-cycle line check
        store(BASE, 32'h0000_0055);
        check("sb_tx_before_start", {31'b0, tx}, 32'd1);
        check("sb_busy_after_push", {31'b0, busy}, 32'd1);
        fr = {1'b1, 8'h55, 1'b0};
        DataAddr = BASE + 32'h4;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("sb_tx_k%0d", k), {31'b0, tx}, {31'b0, fr[k / 4]});
            if (k == 5)  check("sb_status_busy", ReadData, 32'h1);
            if (k == 39) check("sb_busy_last_stop", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        check("sb_busy_drop", {31'b0, busy}, 32'd0);
        check("sb_frames", 32'(frames.size()), 32'd1);
        if (frames.size() > 0) begin
            check("sb_byte", {24'b0, frames[0].data}, 32'h55);
            check("sb_stop", {31'b0, frames[0].stop_ok}, 32'd1);
        end
        frames.delete();

        // Back-to-back "ABC"
        store(BASE, 32'h41);
        store(BASE, 32'h42);
        store(BASE, 32'h43);
        wait_idle(200);
        check("b2b_frames", 32'(frames.size()), 32'd3);
        for (int i = 0; i < frames.size() && i < 3; i++) begin
            check($sformatf("b2b_byte%0d", i), {24'b0, frames[i].data}, 32'h41 + 32'(i));
            check($sformatf("b2b_stop%0d", i), {31'b0, frames[i].stop_ok}, 32'd1);
            if (i > 0)
                check($sformatf("b2b_gap%0d", i), 32'(frames[i].start - frames[i-1].start), 32'd41);
        end
        frames.delete();

        // Overflow: six stores into a depth-4 FIFO
        for (int i = 1; i <= 6; i++) store(BASE, 32'(i));
        check("ovf_flag_set", {31'b0, overflow}, 32'd1);
        DataAddr = BASE + 32'h4;
        #1;
        check("ovf_status", ReadData, 32'h7);
        store(BASE + 32'h4, 32'h0);
        check("ovf_flag_clear", {31'b0, overflow}, 32'd0);
        #1;
        check("ovf_status_after_clear", ReadData, 32'h3);
        wait_idle(400);
        check("ovf_frames", 32'(frames.size()), 32'd5);
        for (int i = 0; i < frames.size() && i < 5; i++)
            check($sformatf("ovf_byte%0d", i), {24'b0, frames[i].data}, 32'(i + 1));
        check("ovf_still_clear", {31'b0, overflow}, 32'd0);
        frames.delete();

        // Reset during bit 3 of 0x55 with two bytes queued
        store(BASE, 32'h55);
        store(BASE, 32'hAA);
        store(BASE, 32'h33);
        repeat (15) @(negedge clk);
        check("rst_pre_tx_bit3", {31'b0, tx}, 32'd0);
        check("rst_pre_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        DataAddr = BASE + 32'h4;
        #1;
        check("rst_tx_high", {31'b0, tx}, 32'd1);
        check("rst_busy_low", {31'b0, busy}, 32'd0);
        check("rst_status", ReadData, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_post_busy", {31'b0, busy}, 32'd0);
        check("rst_post_frames", 32'(frames.size()), 32'd0);
        check("rst_post_tx", {31'b0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the single-cycle RISC-V core's data-store bus (`MemWrite`/`DataAddr`/`WriteData`) as the responder to CPU stores. Byte stores to a data register are queued in a small FIFO and serialized 8N1 on `tx`, LSB first. A status register lets programs poll for space and completion, so test programs (factorial and similar) report results on a real pin instead of relying on the bench watching `DataAddr`.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: word-aligned base of the 2-register window.
- `CLKS_PER_BIT`, default 174: clock cycles per UART bit (20 MHz local clock / 115200 baud); legal range ≥ 2.
- `FIFO_DEPTH`, default 8: TX byte queue depth; power of two, ≥ 2.
- `clk`  in  1: local core clock, all state on rising edge.
- `reset`  in  1: **asynchronous, active-low**. Asserted low clears all state immediately.
- `MemWrite`  in  1: store strobe from core.
- `DataAddr`  in  32: store/load address from core.
- `WriteData`  in  32: store data from core.
- `ReadData`  out  32: combinational read data for the window; 0 outside it.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: FIFO non-empty or frame in progress.
- `overflow`  out  1: sticky, a TXDATA store was dropped.

## Operation
- Register map: `BASE_ADDR+0` TXDATA (W: push `WriteData[7:0]`; R: 0). `BASE_ADDR+4` STATUS (R: `{29'b0, overflow, full, busy}`; W: any value clears `overflow`).
- Push: at rising edge with `MemWrite=1` and `DataAddr==BASE_ADDR`. Accepted if count < `FIFO_DEPTH`, or count == `FIFO_DEPTH` with a pop in the same cycle. Otherwise the byte is dropped and `overflow` is set.
- Simultaneous overflow-set and STATUS-clear cannot occur, because it is one store per cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty, pop into the shift register, clear the baud counter and bit index, then go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=`shift[0]`, held `CLKS_PER_BIT` cycles per bit. The shift register shifts right after each bit. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 with no drift. The bit index is 3 bits and wraps only via the state change.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. The count is one bit wider.
- `tx` is registered (no glitches). `busy` = (state != IDLE) || (count != 0). `full` = (count == `FIFO_DEPTH`).
- Stores to other addresses, and loads, have no side effects.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, FIFO empty, state IDLE. `ReadData` reflects the reset state.
- Push at edge N makes the FIFO non-empty after N. At edge N+1 the FSM pops and `tx` falls. The start bit occupies cycles N+1 .. N+`CLKS_PER_BIT`.
- Frame length is 10×`CLKS_PER_BIT` cycles. For back-to-back bytes, STOP→IDLE costs 1 cycle, so frames repeat every 10×`CLKS_PER_BIT`+1 cycles.
- `busy` rises the edge after the push and falls the edge after the last STOP cycle when the FIFO is empty.
- `ReadData` is combinational in `DataAddr`, `count`, and state. There is no latency, as the single-cycle load path requires.
- Reset asserted mid-frame: `tx` goes high immediately, the queued bytes are discarded, and transmission restarts only on new pushes after release.

## Structure
- Package `mmio_uart_pkg` holds:
  - FSM state enum (IDLE/START/DATA/STOP);
  - register offsets `TXDATA_OFS`=0 and `STATUS_OFS`=4;
  - STATUS bit positions.
- Sub-module `byte_fifo` is a synchronous FIFO with parameter DEPTH and ports push/pop/din/dout/full/empty/count, using the same clock and reset. The top handles address decode, the overflow flag, the FSM, and the baud counter.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, `BASE_ADDR`=0x100.
- Reset: hold `reset`=0 for 22 ns, then release. Expect `tx`=1, `busy`=0, `overflow`=0, and a read of 0x104 returns 0.
- Single byte: store 0x00000055 to 0x100. Expect `tx` low 4 cycles starting the next edge, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. `busy` drops after 40 cycles.
- Back-to-back: store 0x41, 0x42, 0x43 in consecutive cycles. Expect three frames, each 41 cycles apart at the start-bit edge, and decoded bytes "ABC".
- Overflow: issue 6 consecutive stores (0x01..0x06). Expect 0x01 popped at once and 0x02..0x05 queued. 0x06 is dropped and `overflow`=1, and STATUS reads 0x7. Storing to 0x104 then clears `overflow`.
- Reset mid-frame: pull `reset` low at bit 3 of 0x55 with 2 bytes queued. Expect `tx`=1 immediately, and after release `busy`=0 with no further frames.
- Decode isolation: store to 0x0C (value 0x248) and to 0x108. Expect no frame and no state change, and `ReadData`=0 for 0x0C.
